// File: rtl/irq_coalesce_ctrl.sv
// irq_coalesce_ctrl
// Interrupt coalescing controller between fabric event sources and one HPS
// f2h_irq line. Events are latched into PENDING and counted. irq is raised
// when the count reaches THRESH or the accumulation timer reaches TIMEOUT.
// After irq drops, a hold-off gap is enforced before the next irq.
// Software access is through an Avalon-MM slave with fixed read latency 1.
//
// Register map (word addresses):
//   0 PENDING (RO, W1C)   1 MASK (RW)   2 THRESH (RW, 0 acts as 1)
//   3 TIMEOUT (RW, 0 disables)   4 EVCOUNT (RO)   5 TSTAMP (RO)
//
// Optional feature macro: IRQ_COALESCE_TSTAMP_EN
//   defined   : a free-running 32-bit cycle counter is captured into TSTAMP
//               on every IDLE/ACCUM -> FIRE transition
//   undefined : no counter logic; address 5 reads 0
module irq_coalesce_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int CNT_W       = 16,
  parameter int HOLDOFF_CYC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] evt_in,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [31:0]      HOLDOFF_LAST = 32'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  state_t             state;
  state_t             state_next;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_clr;
  logic [NUM_SRC-1:0] pending_upd;
  logic [NUM_SRC-1:0] mask;

  logic [CNT_W-1:0]   thresh;
  logic [CNT_W-1:0]   thresh_eff;
  logic [CNT_W-1:0]   evcount;
  logic [CNT_W-1:0]   evcount_inc;
  logic [CNT_W-1:0]   evcount_next;

  logic [31:0]        timeout;
  logic [31:0]        timer;
  logic [31:0]        timer_inc;
  logic [31:0]        timer_next;
  logic [31:0]        rd_mux;

  logic               wr_pending;
  logic               wr_mask;
  logic               wr_thresh;
  logic               wr_timeout;
  logic               hit;
  logic               live;
  logic               thresh_met;
  logic               timeout_met;

  // Decode writes and compute this cycle's updated pending/count/timer views
  always_comb begin
    wr_pending  = avs_write && (avs_address == 3'd0);
    wr_mask     = avs_write && (avs_address == 3'd1);
    wr_thresh   = avs_write && (avs_address == 3'd2);
    wr_timeout  = avs_write && (avs_address == 3'd3);

    pending_clr = wr_pending ? avs_writedata[NUM_SRC-1:0] : '0;
    pending_upd = (pending & ~pending_clr) | evt_in;

    hit         = |(evt_in & mask);
    live        = |(pending_upd & mask);

    evcount_inc = (hit && (evcount != CNT_MAX)) ? (evcount + CNT_ONE) : evcount;
    thresh_eff  = (thresh == '0) ? CNT_ONE : thresh;
    thresh_met  = (evcount_inc >= thresh_eff);

    timer_inc   = (timer != 32'hFFFF_FFFF) ? (timer + 32'd1) : timer;
    timeout_met = (timeout != 32'd0) && (timer_inc >= timeout);
  end

  // Next-state, next event count and next timer value
  always_comb begin
    state_next   = state;
    evcount_next = evcount_inc;
    timer_next   = timer;

    case (state)
      IDLE: begin
        timer_next = 32'd0;
        if (hit) begin
          if (thresh_met) begin
            state_next = FIRE;
          end else begin
            state_next = ACCUM;
          end
        end
      end

      ACCUM: begin
        timer_next = timer_inc;
        if (!live) begin
          state_next   = IDLE;
          evcount_next = '0;
          timer_next   = 32'd0;
        end else if (thresh_met || timeout_met) begin
          state_next = FIRE;
          timer_next = 32'd0;
        end
      end

      FIRE: begin
        timer_next = 32'd0;
        if (!live) begin
          state_next   = HOLDOFF;
          evcount_next = '0;
        end
      end

      HOLDOFF: begin
        timer_next = timer_inc;
        if (timer_inc >= HOLDOFF_LAST) begin
          timer_next = 32'd0;
          if (live) begin
            state_next = ACCUM;
          end else begin
            state_next   = IDLE;
            evcount_next = '0;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        evcount_next = '0;
        timer_next   = 32'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control registers, event bookkeeping and the registered irq output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      mask    <= '0;
      thresh  <= CNT_ONE;
      timeout <= 32'd0;
      evcount <= '0;
      timer   <= 32'd0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_upd;
      evcount <= evcount_next;
      timer   <= timer_next;
      irq     <= (state_next == FIRE);
      if (wr_mask) begin
        mask <= avs_writedata[NUM_SRC-1:0];
      end
      if (wr_thresh) begin
        thresh <= avs_writedata[CNT_W-1:0];
      end
      if (wr_timeout) begin
        timeout <= avs_writedata;
      end
    end
  end

`ifdef IRQ_COALESCE_TSTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] tstamp;
  logic        tstamp_capture;

  // Capture the cycle counter whenever the FSM enters FIRE from IDLE/ACCUM
  always_comb begin
    tstamp_capture = ((state == IDLE) || (state == ACCUM)) && (state_next == FIRE);
  end

  // Free-running cycle counter and timestamp capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'd0;
      tstamp    <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (tstamp_capture) begin
        tstamp <= cycle_cnt;
      end
    end
  end
`endif

  // Read multiplexer; unmapped bits and addresses read as zero
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      3'd0: rd_mux[NUM_SRC-1:0] = pending;
      3'd1: rd_mux[NUM_SRC-1:0] = mask;
      3'd2: rd_mux[CNT_W-1:0]   = thresh;
      3'd3: rd_mux              = timeout;
      3'd4: rd_mux[CNT_W-1:0]   = evcount;
`ifdef IRQ_COALESCE_TSTAMP_EN
      3'd5: rd_mux              = tstamp;
`endif
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read data, returning the pre-write value one cycle after avs_read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
// tb_irq_coalesce_ctrl
// Self-checking bench for irq_coalesce_ctrl (default build, timestamp disabled).
// A table of register/threshold vectors, hand-written multi-cycle sequences
// and a randomized phase are all checked against a behavioural model.
module tb_irq_coalesce_ctrl;

  localparam int NUM_SRC     = 4;
  localparam int CNT_W       = 16;
  localparam int HOLDOFF_CYC = 8;

  localparam int PH_WAIT   = 0;
  localparam int PH_GATHER = 1;
  localparam int PH_ASSERT = 2;
  localparam int PH_QUIET  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  evt_in;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  irq_coalesce_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .CNT_W      (CNT_W),
    .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .evt_in       (evt_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  evt;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        exp_irq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[20];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;
  int unsigned m_thresh;
  int unsigned m_timeout;
  int unsigned m_count;
  int unsigned m_age;
  int unsigned m_hold;
  int          m_phase;
  logic        m_irq;
  logic [31:0] m_rdata;

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_pend};
      3'd1:    return {28'd0, m_mask};
      3'd2:    return 32'(m_thresh);
      3'd3:    return 32'(m_timeout);
      3'd4:    return 32'(m_count);
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    m_pend    = 4'h0;
    m_mask    = 4'h0;
    m_thresh  = 1;
    m_timeout = 0;
    m_count   = 0;
    m_age     = 0;
    m_hold    = 0;
    m_phase   = PH_WAIT;
    m_irq     = 1'b0;
    m_rdata   = 32'd0;
  endtask

  task automatic modelStep(input logic [3:0] evt, input logic [2:0] addr,
                           input logic rd, input logic wr, input logic [31:0] wdata);
    logic [3:0]  clr;
    logic [3:0]  newp;
    logic        hit;
    logic        live;
    int unsigned th;
    if (rd) m_rdata = modelRead(addr);
    clr  = (wr && addr == 3'd0) ? wdata[3:0] : 4'h0;
    newp = (m_pend & ~clr) | evt;
    hit  = |(evt & m_mask);
    if (hit && m_count < 65535) m_count++;
    live = |(newp & m_mask);
    th   = (m_thresh == 0) ? 1 : m_thresh;
    case (m_phase)
      PH_WAIT: begin
        if (hit) begin
          if (m_count >= th) m_phase = PH_ASSERT;
          else begin
            m_phase = PH_GATHER;
            m_age   = 0;
          end
        end
      end
      PH_GATHER: begin
        m_age++;
        if (!live) begin
          m_phase = PH_WAIT;
          m_count = 0;
        end else if (m_count >= th || (m_timeout != 0 && m_age >= m_timeout)) begin
          m_phase = PH_ASSERT;
        end
      end
      PH_ASSERT: begin
        if (!live) begin
          m_phase = PH_QUIET;
          m_count = 0;
          m_hold  = 0;
        end
      end
      default: begin
        m_hold++;
        if (m_hold >= HOLDOFF_CYC - 1) begin
          if (live) begin
            m_phase = PH_GATHER;
            m_age   = 0;
          end else begin
            m_phase = PH_WAIT;
            m_count = 0;
          end
        end
      end
    endcase
    m_pend = newp;
    if (wr) begin
      case (addr)
        3'd1:    m_mask    = wdata[3:0];
        3'd2:    m_thresh  = wdata & 32'h0000_FFFF;
        3'd3:    m_timeout = wdata;
        default: ;
      endcase
    end
    m_irq = (m_phase == PH_ASSERT);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, checked against the model after the edge
  task automatic applyStimulus(input logic [3:0] evt, input logic [2:0] addr,
                               input logic rd, input logic wr, input logic [31:0] wdata);
    evt_in        = evt;
    avs_address   = addr;
    avs_read      = rd;
    avs_write     = wr;
    avs_writedata = wdata;
    @(posedge clk);
    modelStep(evt, addr, rd, wr, wdata);
    #1;
    checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
    if (rd) checkOutput("model_rdata", avs_readdata, m_rdata);
    evt_in    = 4'h0;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    logic        seen;
    int          lat;
    logic [3:0]  r_evt;
    logic [2:0]  r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_wdata;

    // evt, addr, rd, wr, wdata, exp_irq, exp_rd
    vecs[0]  = '{4'h0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[1]  = '{4'h0, 3'd1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[2]  = '{4'h0, 3'd2, 1'b1, 1'b0, 32'd0, 1'b0, 32'd1};
    vecs[3]  = '{4'h0, 3'd3, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[4]  = '{4'h0, 3'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[5]  = '{4'h0, 3'd5, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[6]  = '{4'h0, 3'd1, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
    vecs[7]  = '{4'h0, 3'd2, 1'b0, 1'b1, 32'd4, 1'b0, 32'd0};
    vecs[8]  = '{4'h1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[9]  = '{4'h1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[10] = '{4'h1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[11] = '{4'h1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
    vecs[12] = '{4'h0, 3'd4, 1'b1, 1'b0, 32'd0, 1'b1, 32'd4};
    vecs[13] = '{4'h0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1};
    vecs[14] = '{4'h0, 3'd0, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
    vecs[15] = '{4'h0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[16] = '{4'h2, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[17] = '{4'h0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2};
    vecs[18] = '{4'h0, 3'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    vecs[19] = '{4'h0, 3'd0, 1'b0, 1'b1, 32'd2, 1'b0, 32'd0};

    reset_n       = 1'b0;
    evt_in        = 4'h0;
    avs_address   = 3'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'd0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_rdata", avs_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register reset values, threshold firing, W1C drop, unmasked source
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].evt, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
      checkOutput($sformatf("table%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      if (vecs[i].rd)
        checkOutput($sformatf("table%0d_rdata", i), avs_readdata, vecs[i].exp_rd);
    end

    // Timeout path: THRESH=100, TIMEOUT=10, one pulse
    repeat (8) applyStimulus(4'h0, 3'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(4'h0, 3'd2, 1'b0, 1'b1, 32'd100);
    applyStimulus(4'h0, 3'd3, 1'b0, 1'b1, 32'd10);
    applyStimulus(4'h1, 3'd0, 1'b0, 1'b0, 32'd0);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      applyStimulus(4'h0, 3'd0, 1'b0, 1'b0, 32'd0);
      if (irq) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput("timeout_latency", {31'd0, (seen && lat >= 10 && lat <= 11)}, 32'd1);

    // Event and W1C on the same bit in FIRE: event wins, irq stays high
    applyStimulus(4'h1, 3'd0, 1'b0, 1'b1, 32'd1);
    checkOutput("w1c_race_irq", {31'd0, irq}, 32'd1);
    applyStimulus(4'h0, 3'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("w1c_race_pending", avs_readdata, 32'd1);
    applyStimulus(4'h0, 3'd2, 1'b0, 1'b1, 32'd1);
    applyStimulus(4'h0, 3'd3, 1'b0, 1'b1, 32'd0);
    applyStimulus(4'h0, 3'd0, 1'b0, 1'b1, 32'd1);
    checkOutput("w1c_drop_irq", {31'd0, irq}, 32'd0);

    // Hold-off: event two cycles after the drop fires only after hold-off and ACCUM
    for (int i = 1; i <= 8; i++) begin
      applyStimulus((i == 2) ? 4'h1 : 4'h0, 3'd0, 1'b0, 1'b0, 32'd0);
      checkOutput($sformatf("holdoff_c%0d_irq", i), {31'd0, irq}, {31'd0, (i == 8)});
    end

    // Asynchronous reset while in FIRE
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("async_reset_rdata", avs_readdata, 32'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].evt, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
      checkOutput($sformatf("post_reset_reg%0d", i), avs_readdata, vecs[i].exp_rd);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r_evt  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      r_rd   = ($urandom_range(0, 2) == 0);
      r_wr   = ($urandom_range(0, 3) == 0);
      r_addr = 3'($urandom_range(0, 7));
      case (r_addr)
        3'd2:    r_wdata = 32'($urandom_range(0, 5));
        3'd3:    r_wdata = 32'($urandom_range(0, 15));
        default: r_wdata = $urandom;
      endcase
      applyStimulus(r_evt, r_addr, r_rd, r_wr, r_wdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
